aes_spi_frame: RTL and testbench

Parametrised SPI front end for the AES accelerator. It replaces the fixed 128-bit key/plaintext shift interface with a framed protocol that carries a command byte, an optional key, an optional IV and one data block. It adds CBC chaining, frame-length checking and an error flag. It sits between the MCU SPI pins and the AES core, samples SPI in the `clk` domain, and drives the core through a start/done handshake.

---
 rtl/aes_pkg.sv | 26 ++
 rtl/spi_sync_edge.sv | 37 +++
 rtl/aes_spi_frame.sv | 175 +++++++++++++++++
 tb/tb_aes_spi_frame.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and helpers for the framed SPI front end of the AES accelerator.
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_CHECK,
        ST_START,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam int CMD_MODE = 0;
    localparam int CMD_KEY  = 1;
    localparam int CMD_IV   = 2;

    function automatic int frame_len(input int key_w, input int block_w, input logic [7:0] cmd);
        return 8 + (cmd[CMD_KEY] ? key_w : 0) + (cmd[CMD_IV] ? block_w : 0) + block_w;
    endfunction

    // Counter must reach the longest frame plus one so over-long frames stay distinguishable.
    function automatic int cnt_width(input int key_w, input int block_w);
        return $clog2(8 + key_w + 2 * block_w + 2);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser followed by registered rise/fall pulse generation.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   last_reg;
    logic                   rise_reg;
    logic                   fall_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= '0;
            last_reg <= 1'b0;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                sync_reg[i] <= sync_reg[i-1];
            end
            sync_reg[0] <= din;
            last_reg    <= sync_reg[SYNC_STAGES-1];
            rise_reg    <= sync_reg[SYNC_STAGES-1] & ~last_reg;
            fall_reg    <= ~sync_reg[SYNC_STAGES-1] & last_reg;
        end
    end

    assign rise = rise_reg;
    assign fall = fall_reg;

endmodule

// File: rtl/aes_spi_frame.sv
// Framed SPI receiver/transmitter driving an AES core with ECB/CBC chaining and frame checking.
module aes_spi_frame
    import aes_pkg::*;
#(
    parameter int KEY_W       = 128,
    parameter int BLOCK_W     = 128,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sck,
    input  logic               sdi,
    output logic               sdo,
    input  logic               load,
    output logic               done,
    output logic               err,
    output logic               core_start,
    output logic [KEY_W-1:0]   core_key,
    output logic [BLOCK_W-1:0] core_in,
    input  logic               core_done,
    input  logic [BLOCK_W-1:0] core_out
);

    localparam int PAY_W   = KEY_W + 2 * BLOCK_W;
    localparam int MAX_LEN = 8 + PAY_W;
    localparam int CNT_W   = cnt_width(KEY_W, BLOCK_W);

    state_t state_reg, state_next;

    logic                   sck_rise, sck_fall, load_rise, load_fall;
    logic [SYNC_STAGES-1:0] sdi_sync_reg;
    logic                   load_lvl_reg;
    logic [CNT_W-1:0]       bit_cnt_reg;
    logic [PAY_W-1:0]       rx_reg;
    logic [7:0]             cmd_reg;
    logic [KEY_W-1:0]       key_reg;
    logic [BLOCK_W-1:0]     chain_reg, core_in_reg, tx_reg;
    logic                   mode_reg, err_reg, collide_reg;

    logic                   sdi_s, frame_ok;
    logic [KEY_W-1:0]       key_field;
    logic [BLOCK_W-1:0]     iv_field, data_field, chain_src, block_in;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .clk   (clk),
        .reset (reset),
        .din   (sck),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_load_sync (
        .clk   (clk),
        .reset (reset),
        .din   (load),
        .rise  (load_rise),
        .fall  (load_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sdi_sync_reg <= '0;
        end else begin
            for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                sdi_sync_reg[i] <= sdi_sync_reg[i-1];
            end
            sdi_sync_reg[0] <= sdi;
        end
    end

    assign sdi_s = sdi_sync_reg[SYNC_STAGES-1];

    // The last bit received sits at rx_reg[0], so the data block is always the low slice.
    assign data_field = rx_reg[BLOCK_W-1:0];
    assign iv_field   = rx_reg[BLOCK_W +: BLOCK_W];
    assign key_field  = cmd_reg[CMD_IV] ? rx_reg[2*BLOCK_W +: KEY_W] : rx_reg[BLOCK_W +: KEY_W];
    assign chain_src  = cmd_reg[CMD_IV] ? iv_field : chain_reg;
    assign block_in   = cmd_reg[CMD_MODE] ? (data_field ^ chain_src) : data_field;
    assign frame_ok   = (bit_cnt_reg == CNT_W'(frame_len(KEY_W, BLOCK_W, cmd_reg)))
                        && (cmd_reg[7:3] == 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:  if (load_rise) state_next = ST_RECV;
            ST_RECV:  if (load_fall) state_next = ST_CHECK;
            ST_CHECK: state_next = frame_ok ? ST_START : ST_IDLE;
            ST_START: state_next = ST_WAIT;
            ST_WAIT:  if (core_done) state_next = ST_DONE;
            ST_DONE:  if (load_rise) state_next = ST_RECV;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_lvl_reg <= 1'b0;
            bit_cnt_reg  <= '0;
            rx_reg       <= '0;
            cmd_reg      <= '0;
            key_reg      <= '0;
            chain_reg    <= '0;
            core_in_reg  <= '0;
            tx_reg       <= '0;
            mode_reg     <= 1'b0;
            err_reg      <= 1'b0;
            collide_reg  <= 1'b0;
        end else begin
            if (load_rise) begin
                load_lvl_reg <= 1'b1;
            end else if (load_fall) begin
                load_lvl_reg <= 1'b0;
            end

            if (load_rise && (state_reg == ST_IDLE || state_reg == ST_DONE)) begin
                bit_cnt_reg <= '0;
                cmd_reg     <= '0;
                err_reg     <= 1'b0;
                collide_reg <= 1'b0;
            end

            if (state_reg == ST_RECV && sck_rise && load_lvl_reg) begin
                rx_reg <= {rx_reg[PAY_W-2:0], sdi_s};
                if (bit_cnt_reg == CNT_W'(7)) begin
                    cmd_reg <= {rx_reg[6:0], sdi_s};
                end
                if (bit_cnt_reg != CNT_W'(MAX_LEN + 1)) begin
                    bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                end
            end

            if (state_reg == ST_CHECK) begin
                if (frame_ok) begin
                    if (cmd_reg[CMD_KEY]) key_reg <= key_field;
                    if (cmd_reg[CMD_IV]) chain_reg <= iv_field;
                    mode_reg    <= cmd_reg[CMD_MODE];
                    core_in_reg <= block_in;
                end else begin
                    err_reg <= 1'b1;
                end
            end

            // A frame arriving while the core is busy is dropped and reported on completion.
            if ((state_reg == ST_START || state_reg == ST_WAIT) && load_rise) begin
                collide_reg <= 1'b1;
            end

            if (state_reg == ST_WAIT && core_done) begin
                tx_reg <= core_out;
                if (mode_reg) chain_reg <= core_out;
                if (collide_reg || load_rise) err_reg <= 1'b1;
            end

            if (state_reg == ST_DONE && !load_lvl_reg && sck_fall) begin
                tx_reg <= {tx_reg[BLOCK_W-2:0], 1'b0};
            end
        end
    end

    assign sdo        = tx_reg[BLOCK_W-1];
    assign done       = (state_reg == ST_DONE);
    assign err        = err_reg;
    assign core_start = (state_reg == ST_START);
    assign core_key   = key_reg;
    assign core_in    = core_in_reg;

endmodule

// File: tb/tb_aes_spi_frame.sv
// Self-checking bench for aes_spi_frame with a stand-in cipher core and a frame-level reference model.
module tb_aes_spi_frame;

    localparam int KW   = 128;
    localparam int BW   = 128;
    localparam int SS   = 2;
    localparam int HALF = SS + 2;

    logic          clk = 1'b0;
    logic          reset, sck, sdi, load, core_done;
    logic [BW-1:0] core_out;
    logic          sdo, done, err, core_start;
    logic [KW-1:0] core_key;
    logic [BW-1:0] core_in;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int core_lat = 4;

    logic [BW-1:0] cap_in;
    logic [KW-1:0] cap_key;
    logic          done_at_cd, done_after_cd, sdo_after_cd;

    // Reference model state: current key and CBC chaining value.
    logic [KW-1:0] key_m;
    logic [BW-1:0] chain_m;

    aes_spi_frame #(.KEY_W(KW), .BLOCK_W(BW), .SYNC_STAGES(SS)) dut (
        .clk        (clk),
        .reset      (reset),
        .sck        (sck),
        .sdi        (sdi),
        .sdo        (sdo),
        .load       (load),
        .done       (done),
        .err        (err),
        .core_start (core_start),
        .core_key   (core_key),
        .core_in    (core_in),
        .core_done  (core_done),
        .core_out   (core_out)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] fake_cipher(input logic [BW-1:0] blk, input logic [KW-1:0] key);
        logic [BW-1:0] t;
        t = blk ^ key;
        return ({t[114:0], t[127:115]} + 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0) ^ {key[63:0], key[127:64]};
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (core_start === 1'b1) start_cnt++;
        end
    end

    // Stand-in cipher core: fixed transform after a programmable latency, one-cycle done pulse.
    initial begin
        core_done = 1'b0;
        core_out  = '0;
        forever begin
            @(negedge clk);
            if (core_start === 1'b1) begin
                cap_in  = core_in;
                cap_key = core_key;
                repeat (core_lat) @(negedge clk);
                core_out   = fake_cipher(cap_in, cap_key);
                done_at_cd = done;
                core_done  = 1'b1;
                @(negedge clk);
                core_done     = 1'b0;
                done_after_cd = done;
                sdo_after_cd  = sdo;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mk_frame(input logic [7:0] cmd, input logic [KW-1:0] key, input logic [BW-1:0] iv,
                            input logic [BW-1:0] data, output logic [511:0] f, output int n);
        f = {504'd0, cmd};
        n = 8;
        if (cmd[1]) begin f = (f << KW) | {384'd0, key}; n += KW; end
        if (cmd[2]) begin f = (f << BW) | {384'd0, iv}; n += BW; end
        f = (f << BW) | {384'd0, data};
        n += BW;
    endtask

    task automatic model_apply(input logic [7:0] cmd, input logic [KW-1:0] key, input logic [BW-1:0] iv,
                               input logic [BW-1:0] data, output logic [BW-1:0] exp_in, output logic [BW-1:0] ct);
        if (cmd[1]) key_m = key;
        if (cmd[2]) chain_m = iv;
        exp_in = cmd[0] ? (data ^ chain_m) : data;
        ct = fake_cipher(exp_in, key_m);
        if (cmd[0]) chain_m = ct;
    endtask

    task automatic send_frame(input logic [511:0] bits, input int n);
        load = 1'b1;
        tick(HALF);
        for (int i = n - 1; i >= 0; i--) begin
            sdi = bits[i];
            tick(HALF);
            sck = 1'b1;
            tick(HALF);
            sck = 1'b0;
        end
        tick(HALF);
        load = 1'b0;
    endtask

    task automatic wait_done(input string name, output bit ok);
        int cyc;
        cyc = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            tick(1);
            cyc++;
        end
        ok = (done === 1'b1);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: done=%b after %0d cycles, required 1", name, done, cyc);
        end
    endtask

    task automatic read_block(output logic [BW-1:0] v, output logic extra);
        for (int i = 0; i < BW; i++) begin
            v[BW-1-i] = sdo;
            sck = 1'b1;
            tick(HALF);
            sck = 1'b0;
            tick(HALF + 1);
        end
        extra = sdo;
    endtask

    task automatic wait_start(output int lat);
        lat = 0;
        while (core_start !== 1'b1 && lat < 20) begin
            tick(1);
            lat++;
        end
    endtask

    task automatic run_valid(input string name, input logic [7:0] cmd, input logic [KW-1:0] key,
                             input logic [BW-1:0] iv, input logic [BW-1:0] data);
        logic [511:0] f;
        int n, lat, sc0;
        logic [BW-1:0] exp_in, ct, got;
        logic extra;
        bit ok;
        mk_frame(cmd, key, iv, data, f, n);
        model_apply(cmd, key, iv, data, exp_in, ct);
        sc0 = start_cnt;
        core_lat = $urandom_range(1, 8);
        done_after_cd = 1'bx;
        send_frame(f, n);
        wait_start(lat);
        checks++;
        if (lat != SS + 3) begin
            errors++;
            $display("FAIL %s_start_latency: got %0d cycles, required %0d", name, lat, SS + 3);
        end
        checks++;
        if (core_in !== exp_in) begin
            errors++;
            $display("FAIL %s_core_in: got %h, required %h", name, core_in, exp_in);
        end
        checks++;
        if (core_key !== key_m) begin
            errors++;
            $display("FAIL %s_core_key: got %h, required %h", name, core_key, key_m);
        end
        wait_done(name, ok);
        tick(1);
        if (ok) begin
            checks++;
            if (done_at_cd !== 1'b0 || done_after_cd !== 1'b1) begin
                errors++;
                $display("FAIL %s_done_timing: done before/after core_done %b/%b, required 0/1",
                         name, done_at_cd, done_after_cd);
            end
            checks++;
            if (sdo_after_cd !== ct[BW-1]) begin
                errors++;
                $display("FAIL %s_sdo_msb: got %b, required %b", name, sdo_after_cd, ct[BW-1]);
            end
            checks++;
            if (err !== 1'b0) begin
                errors++;
                $display("FAIL %s_err: got %b, required 0", name, err);
            end
        end
        read_block(got, extra);
        checks++;
        if (got !== ct) begin
            errors++;
            $display("FAIL %s_readback: got %h, required %h", name, got, ct);
        end
        checks++;
        if (extra !== 1'b0) begin
            errors++;
            $display("FAIL %s_zero_fill: got %b, required 0", name, extra);
        end
        checks++;
        if (start_cnt != sc0 + 1) begin
            errors++;
            $display("FAIL %s_start_pulses: got %0d, required 1", name, start_cnt - sc0);
        end
        $display("frame %s cmd=%02h ct=%h", name, cmd, got);
    endtask

    task automatic run_reject(input string name, input logic [511:0] f, input int n);
        int sc0;
        sc0 = start_cnt;
        send_frame(f, n);
        tick(3 * SS + 10);
        checks++;
        if (err !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s_reject: err/done got %b/%b, required 1/0", name, err, done);
        end
        checks++;
        if (start_cnt != sc0) begin
            errors++;
            $display("FAIL %s_no_start: got %0d pulses, required 0", name, start_cnt - sc0);
        end
        $display("frame %s bits=%0d err=%b", name, n, err);
    endtask

    task automatic check_outputs_clear(input string name);
        checks++;
        if ({done, err, sdo, core_start} !== 4'b0000 || core_key !== '0 || core_in !== '0) begin
            errors++;
            $display("FAIL %s_clear: done=%b err=%b sdo=%b start=%b key=%h in=%h, required all 0",
                     name, done, err, sdo, core_start, core_key, core_in);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; sck = 1'b0; sdi = 1'b0;
        tick(1);
        check_outputs_clear("reset");
        tick(4);
        reset = 1'b0;
        key_m = '0;
        chain_m = '0;
        tick(2);
        $display("reset released");
    endtask

    task automatic test_ecb();
        run_valid("ecb", 8'h02, {$urandom, $urandom, $urandom, $urandom}, '0,
                  {$urandom, $urandom, $urandom, $urandom});
    endtask

    task automatic test_cbc_chain();
        run_valid("cbc_first", 8'h07, {$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        run_valid("cbc_chain", 8'h01, '0, '0, {$urandom, $urandom, $urandom, $urandom});
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            run_valid($sformatf("rand%0d", i), 8'($urandom_range(0, 7)),
                      {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                      {$urandom, $urandom, $urandom, $urandom});
        end
    endtask

    task automatic test_bad_frames();
        logic [511:0] f;
        int n;
        mk_frame(8'h02, {$urandom, $urandom, $urandom, $urandom}, '0, {$urandom, $urandom, $urandom, $urandom}, f, n);
        run_reject("short", f >> 1, n - 1);
        mk_frame(8'h00, '0, '0, {$urandom, $urandom, $urandom, $urandom}, f, n);
        run_reject("long", (f << 1) | 512'd1, n + 1);
        mk_frame(8'h08, '0, '0, {$urandom, $urandom, $urandom, $urandom}, f, n);
        run_reject("reserved", f, n);
        run_valid("old_key", 8'h00, '0, '0, {$urandom, $urandom, $urandom, $urandom});
    endtask

    task automatic test_collision();
        logic [511:0] fa, fb;
        int na, nb, lat;
        logic [BW-1:0] exp_in, ct, got;
        logic extra;
        mk_frame(8'h01, '0, '0, {$urandom, $urandom, $urandom, $urandom}, fa, na);
        model_apply(8'h01, '0, '0, fa[BW-1:0], exp_in, ct);
        mk_frame(8'h07, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom}, fb, nb);
        core_lat = 300;
        send_frame(fa, na);
        wait_start(lat);
        send_frame(fb, nb);
        tick(10);
        checks++;
        if (done !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL collision_flags: done/err got %b/%b, required 1/1", done, err);
        end
        read_block(got, extra);
        checks++;
        if (got !== ct) begin
            errors++;
            $display("FAIL collision_readback: got %h, required %h", got, ct);
        end
        $display("frame collision err=%b ct=%h", err, got);
        run_valid("after_collision", 8'h01, '0, '0, {$urandom, $urandom, $urandom, $urandom});
    endtask

    task automatic test_reset_mid_frame();
        load = 1'b1;
        tick(HALF);
        for (int i = 0; i < 40; i++) begin
            sdi = 1'($urandom);
            tick(HALF);
            sck = 1'b1;
            tick(HALF);
            sck = 1'b0;
        end
        reset = 1'b1; load = 1'b0; sck = 1'b0;
        tick(1);
        check_outputs_clear("reset_mid");
        tick(4);
        reset = 1'b0;
        key_m = '0;
        chain_m = '0;
        $display("reset mid-frame");
    endtask

    task automatic test_reset_in_wait();
        logic [511:0] f;
        int n, lat, seen;
        logic [BW-1:0] exp_in, ct;
        mk_frame(8'h03, {$urandom, $urandom, $urandom, $urandom}, '0, {$urandom, $urandom, $urandom, $urandom}, f, n);
        model_apply(8'h03, f[2*BW-1:BW], '0, f[BW-1:0], exp_in, ct);
        core_lat = 40;
        send_frame(f, n);
        wait_start(lat);
        tick(5);
        reset = 1'b1;
        tick(1);
        check_outputs_clear("reset_wait");
        tick(4);
        reset = 1'b0;
        key_m = '0;
        chain_m = '0;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            tick(1);
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL late_core_done: done high for %0d cycles, required 0", seen);
        end
        $display("reset in wait, late core_done ignored");
        run_valid("post_reset_ecb", 8'h00, '0, '0, {$urandom, $urandom, $urandom, $urandom});
        run_valid("post_reset_cbc", 8'h01, '0, '0, {$urandom, $urandom, $urandom, $urandom});
    endtask

    initial begin
        test_reset();
        test_ecb();
        test_cbc_chain();
        test_random();
        test_bad_frames();
        test_collision();
        test_reset_mid_frame();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
